// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, receiver state encoding
// and a helper that builds the data mask for a given data_bits setting.
package uart_pkg;

    localparam logic [1:0] PAR_SPACE = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_MARK  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP1     = 3'd4,
        ST_STOP2     = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } rx_state_t;

    // Mask covering the active data bits (data_bits + 5 of them).
    function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
        logic [2:0] drop;
        drop = 3'd3 - {1'b0, data_bits};
        return 8'hFF >> drop;
    endfunction

endpackage

// File: rtl/uart_rx_parity.sv
// Combinational expected-parity bit for a received word.
// Ports:
//   data_i        received word, right-justified
//   data_bits_i   data bit count minus 5
//   parity_mode_i space / odd / even / mark
//   parity_o      parity bit the transmitter should have sent
module uart_rx_parity
    import uart_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic [1:0] data_bits_i,
    input  logic [1:0] parity_mode_i,
    output logic       parity_o
);

    logic [7:0] masked;

    always_comb begin
        masked   = data_i & data_mask(data_bits_i);
        parity_o = 1'b0;
        case (parity_mode_i)
            PAR_SPACE: parity_o = 1'b0;
            PAR_MARK:  parity_o = 1'b1;
            PAR_EVEN:  parity_o = ^masked;
            PAR_ODD:   parity_o = ~^masked;
            default:   parity_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: programmable 5-8 data bits, optional parity, 1 or 2 stop
// bits. Received words are presented on a valid/ready port together with
// parity and framing flags; a sticky overrun flags words dropped because
// the previous word was still pending.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx              asynchronous serial input, idle high
//   data_bits       data bit count minus 5
//   has_parity      parity bit follows the data bits
//   parity_mode     space / odd / even / mark
//   extra_stop_bit  two stop bits expected
//   clock_divisor   bit period minus one, in clk cycles (>= 3)
//   out_data        received word, right-justified
//   out_valid       word pending, held until out_ready
//   out_ready       consumer accept
//   parity_error    parity flag for out_data
//   framing_error   stop bit flag for out_data
//   overrun         sticky: frame completed while a word was pending
//   busy            receiver not idle
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVISOR_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx,
    input  logic [1:0]                     data_bits,
    input  logic                           has_parity,
    input  logic [1:0]                     parity_mode,
    input  logic                           extra_stop_bit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clock_divisor,
    output logic [7:0]                     out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           parity_error,
    output logic                           framing_error,
    output logic                           overrun,
    output logic                           busy
);

    localparam int W = CLOCK_DIVISOR_WIDTH;

    // Synchronizer plus one history flop for falling-edge detection.
    logic rx_meta_q, rx_s_q, rx_prev_q;

    rx_state_t state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [2:0]   bitn_q, bitn_d;
    logic [7:0]   sr_q, sr_d;
    logic         par_bit_q, par_bit_d;
    logic         stop_bad_q, stop_bad_d;

    // Configuration captured at the start edge.
    logic [1:0]   cfg_bits_q, cfg_bits_d;
    logic         cfg_par_q, cfg_par_d;
    logic [1:0]   cfg_pmode_q, cfg_pmode_d;
    logic         cfg_stop2_q, cfg_stop2_d;
    logic [W-1:0] cfg_div_q, cfg_div_d;

    logic [7:0]   data_q, data_d;
    logic         valid_q, valid_d;
    logic         pe_q, pe_d;
    logic         fe_q, fe_d;
    logic         ovr_q, ovr_d;

    logic         tick, frame_end, stop_bad_now, handshake, exp_par;
    logic [2:0]   shamt;
    logic [7:0]   word;

    // Bits arrive LSB first and enter at the MSB end; shift down so the
    // word is right-justified with zeros above the active width.
    assign shamt = 3'd3 - {1'b0, cfg_bits_q};
    assign word  = sr_q >> shamt;

    uart_rx_parity u_parity (
        .data_i        (word),
        .data_bits_i   (cfg_bits_q),
        .parity_mode_i (cfg_pmode_q),
        .parity_o      (exp_par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bitn_q      <= '0;
            sr_q        <= '0;
            par_bit_q   <= 1'b0;
            stop_bad_q  <= 1'b0;
            cfg_bits_q  <= '0;
            cfg_par_q   <= 1'b0;
            cfg_pmode_q <= '0;
            cfg_stop2_q <= 1'b0;
            cfg_div_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            pe_q        <= 1'b0;
            fe_q        <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitn_q      <= bitn_d;
            sr_q        <= sr_d;
            par_bit_q   <= par_bit_d;
            stop_bad_q  <= stop_bad_d;
            cfg_bits_q  <= cfg_bits_d;
            cfg_par_q   <= cfg_par_d;
            cfg_pmode_q <= cfg_pmode_d;
            cfg_stop2_q <= cfg_stop2_d;
            cfg_div_q   <= cfg_div_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            pe_q        <= pe_d;
            fe_q        <= fe_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitn_d       = bitn_q;
        sr_d         = sr_q;
        par_bit_d    = par_bit_q;
        stop_bad_d   = stop_bad_q;
        cfg_bits_d   = cfg_bits_q;
        cfg_par_d    = cfg_par_q;
        cfg_pmode_d  = cfg_pmode_q;
        cfg_stop2_d  = cfg_stop2_q;
        cfg_div_d    = cfg_div_q;
        data_d       = data_q;
        valid_d      = valid_q;
        pe_d         = pe_q;
        fe_d         = fe_q;
        ovr_d        = ovr_q;
        frame_end    = 1'b0;
        stop_bad_now = stop_bad_q;
        tick         = (cnt_q == '0);
        handshake    = valid_q && out_ready;

        if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        // Bit timer: runs in every in-frame state, sample on zero.
        if (state_q != ST_IDLE && state_q != ST_WAIT_IDLE) begin
            if (tick) cnt_d = cfg_div_q;
            else      cnt_d = cnt_q - W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    cfg_bits_d  = data_bits;
                    cfg_par_d   = has_parity;
                    cfg_pmode_d = parity_mode;
                    cfg_stop2_d = extra_stop_bit;
                    cfg_div_d   = clock_divisor;
                    // Half a bit period puts every later sample mid-bit.
                    cnt_d       = clock_divisor >> 1;
                    bitn_d      = '0;
                    stop_bad_d  = 1'b0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        sr_d    = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    sr_d   = {rx_s_q, sr_q[7:1]};
                    bitn_d = bitn_q + 3'd1;
                    if (bitn_q == ({1'b0, cfg_bits_q} + 3'd4))
                        state_d = cfg_par_q ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_bit_d = rx_s_q;
                    state_d   = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (tick) begin
                    stop_bad_now = !rx_s_q;
                    stop_bad_d   = stop_bad_now;
                    if (cfg_stop2_q) state_d = ST_STOP2;
                    else             frame_end = 1'b1;
                end
            end
            ST_STOP2: begin
                if (tick) begin
                    stop_bad_now = stop_bad_q | !rx_s_q;
                    stop_bad_d   = stop_bad_now;
                    frame_end    = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_end) begin
            // A break keeps the line low; wait for it to release so the
            // low level is not mistaken for another start bit.
            state_d = stop_bad_now ? ST_WAIT_IDLE : ST_IDLE;
            if (!valid_q || handshake) begin
                data_d  = word;
                pe_d    = cfg_par_q && (par_bit_q != exp_par);
                fe_d    = stop_bad_now;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign parity_error  = pe_q;
    assign framing_error = fe_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
